// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter between I-cache and D-cache for one fixed-latency memory.
// Define MEM_ARB_FAIR_EN for round-robin arbitration; default is fixed D-over-I priority.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_grant,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_grant,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_stall,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned CntW = 4;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic              r_own_d;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [CntW-1:0]   r_cnt;

    logic w_win;
    logic w_pick_d;
    logic w_issue;
    logic w_done;

    assign w_win = i_req | d_req;

`ifdef MEM_ARB_FAIR_EN
    // Remembers who was served last; starts as I so D wins the first tie.
    logic r_last_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_d <= 1'b0;
        end else if (r_state == StIdle && w_win) begin
            r_last_d <= w_pick_d;
        end
    end

    assign w_pick_d = d_req & (~i_req | ~r_last_d);
`else
    assign w_pick_d = d_req;
`endif

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_win) w_state_next = StIssue;
            StIssue: if (!mem_stall) w_state_next = StWait;
            StWait:  if (r_cnt == '0) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_own_d <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            unique case (r_state)
                StIdle: begin
                    // Fields are captured once here; requester changes later are ignored.
                    if (w_win) begin
                        r_own_d <= w_pick_d;
                        r_wr    <= w_pick_d & d_wr;
                        r_addr  <= w_pick_d ? d_addr : i_addr;
                        r_wdata <= w_pick_d ? d_wdata : '0;
                    end
                end
                StIssue: begin
                    if (!mem_stall) r_cnt <= CntW'(LATENCY - 1);
                end
                StWait: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (r_state != StIdle);
    assign w_issue = (r_state == StIssue);
    assign w_done  = (r_state == StWait) && (r_cnt == '0);

    assign i_grant = busy & ~r_own_d;
    assign d_grant = busy & r_own_d;

    assign mem_rd    = w_issue & ~r_wr;
    assign mem_wr    = w_issue & r_wr;
    assign mem_addr  = w_issue ? r_addr : '0;
    assign mem_wdata = w_issue ? r_wdata : '0;

    assign i_done  = w_done & ~r_own_d;
    assign d_done  = w_done & r_own_d;
    assign i_rdata = i_done ? mem_rdata : '0;
    assign d_rdata = d_done ? mem_rdata : '0;

endmodule
